vec_div: RTL and testbench

Sequential elementwise fixed-point divider: the inverse of the vector multiply unit. It computes `o_vec_quot[i] = i_vec_a[i] / i_vec_b[i]` for all lanes in parallel, using a shared-control, per-lane restoring divider. It sits beside the combinational vector mul/add/dot unit in the vector datapath. Operands and results use the same signed `FIXPOINT_WIDTH` fixed-point format, so results can feed straight back into the multiply/add/dot path.

---
 rtl/vec_div.sv | 187 ++++++++++++++++++
 tb/tb_vec_div.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_div.sv
// Sequential elementwise fixed-point divider.
// Every lane runs its own MSB-first restoring divider. All lanes share one
// FSM and one iteration counter. Operands and results are signed Q(W-F).F
// values, so the results can go straight back into the mul/add/dot path.
module vec_div #(
  parameter int VEC_SIZE       = 16,
  parameter int FIXPOINT_WIDTH = 32,
  parameter int FRAC_BITS      = 16
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst_n,
  input  logic                                    i_start,
  input  logic [VEC_SIZE-1:0][FIXPOINT_WIDTH-1:0] i_vec_a,
  input  logic [VEC_SIZE-1:0][FIXPOINT_WIDTH-1:0] i_vec_b,
  output logic                                    o_busy,
  output logic                                    o_done,
  output logic [VEC_SIZE-1:0][FIXPOINT_WIDTH-1:0] o_vec_quot,
  output logic [VEC_SIZE-1:0]                     o_div_zero,
  output logic [VEC_SIZE-1:0]                     o_ovf
);

  localparam int W     = FIXPOINT_WIDTH;
  localparam int N     = W + FRAC_BITS;
  localparam int CNT_W = $clog2(N + 1);

  // The counter goes one step past the last iteration. That extra RUN cycle
  // is the finalize edge, which sets the required N+1 cycle latency.
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(N);
  localparam logic [N-1:0]     POS_LIMIT = (N'(1) << (W - 1)) - N'(1);
  localparam logic [N-1:0]     NEG_LIMIT = N'(1) << (W - 1);
  localparam logic [W-1:0]     SAT_POS   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]     SAT_NEG   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                         state_q;
  logic [CNT_W-1:0]               cnt_q;
  logic                           busy_q;
  logic                           done_q;
  logic [VEC_SIZE-1:0]            sign_q;
  logic [VEC_SIZE-1:0]            a_neg_q;
  logic [VEC_SIZE-1:0]            a_zero_q;
  logic [VEC_SIZE-1:0][W-1:0]     abs_b_q;
  logic [VEC_SIZE-1:0][N-1:0]     dvd_q;
  logic [VEC_SIZE-1:0][N-1:0]     quo_q;
  logic [VEC_SIZE-1:0][W:0]       rem_q;
  logic [VEC_SIZE-1:0][W-1:0]     quot_q;
  logic [VEC_SIZE-1:0]            div_zero_q;
  logic [VEC_SIZE-1:0]            ovf_q;

  logic [VEC_SIZE-1:0][W-1:0]     abs_a_d;
  logic [VEC_SIZE-1:0][W-1:0]     abs_b_d;
  logic [VEC_SIZE-1:0][W+1:0]     rem_shift;
  logic [VEC_SIZE-1:0][W:0]       rem_d;
  logic [VEC_SIZE-1:0][N-1:0]     dvd_d;
  logic [VEC_SIZE-1:0][N-1:0]     quo_d;
  logic [VEC_SIZE-1:0][W-1:0]     quot_d;
  logic [VEC_SIZE-1:0]            div_zero_d;
  logic [VEC_SIZE-1:0]            ovf_d;

  // Operand magnitudes at accept time. The most negative value maps to 2^(W-1), which fits in W unsigned bits.
  always_comb begin
    abs_a_d = '0;
    abs_b_d = '0;
    for (int i = 0; i < VEC_SIZE; i++) begin
      abs_a_d[i] = i_vec_a[i][W-1] ? (~i_vec_a[i] + W'(1)) : i_vec_a[i];
      abs_b_d[i] = i_vec_b[i][W-1] ? (~i_vec_b[i] + W'(1)) : i_vec_b[i];
    end
  end

  // One restoring-division step per lane: shift in the next dividend bit, then subtract the divisor if it fits.
  always_comb begin
    rem_shift = '0;
    rem_d     = '0;
    dvd_d     = '0;
    quo_d     = '0;
    for (int i = 0; i < VEC_SIZE; i++) begin
      rem_shift[i] = {rem_q[i], dvd_q[i][N-1]};
      dvd_d[i]     = {dvd_q[i][N-2:0], 1'b0};
      if (rem_shift[i] >= {2'b00, abs_b_q[i]}) begin
        rem_d[i] = rem_shift[i][W:0] - {1'b0, abs_b_q[i]};
        quo_d[i] = {quo_q[i][N-2:0], 1'b1};
      end else begin
        rem_d[i] = rem_shift[i][W:0];
        quo_d[i] = {quo_q[i][N-2:0], 1'b0};
      end
    end
  end

  // Per-lane result: divide-by-zero codes first, then saturation, then the signed quotient.
  always_comb begin
    quot_d     = '0;
    div_zero_d = '0;
    ovf_d      = '0;
    for (int i = 0; i < VEC_SIZE; i++) begin
      if (abs_b_q[i] == '0) begin
        div_zero_d[i] = 1'b1;
        if (a_zero_q[i]) begin
          quot_d[i] = '0;
        end else if (a_neg_q[i]) begin
          quot_d[i] = SAT_NEG;
        end else begin
          quot_d[i] = SAT_POS;
        end
      end else if (!sign_q[i] && (quo_q[i] > POS_LIMIT)) begin
        quot_d[i] = SAT_POS;
        ovf_d[i]  = 1'b1;
      end else if (sign_q[i] && (quo_q[i] > NEG_LIMIT)) begin
        quot_d[i] = SAT_NEG;
        ovf_d[i]  = 1'b1;
      end else if (sign_q[i]) begin
        quot_d[i] = ~quo_q[i][W-1:0] + W'(1);
      end else begin
        quot_d[i] = quo_q[i][W-1:0];
      end
    end
  end

  // Control FSM with its registered outputs, plus all per-lane datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sign_q     <= '0;
      a_neg_q    <= '0;
      a_zero_q   <= '0;
      abs_b_q    <= '0;
      dvd_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      div_zero_q <= '0;
      ovf_q      <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (i_start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            for (int i = 0; i < VEC_SIZE; i++) begin
              sign_q[i]   <= i_vec_a[i][W-1] ^ i_vec_b[i][W-1];
              a_neg_q[i]  <= i_vec_a[i][W-1];
              a_zero_q[i] <= (i_vec_a[i] == '0);
              abs_b_q[i]  <= abs_b_d[i];
              dvd_q[i]    <= {abs_a_d[i], {FRAC_BITS{1'b0}}};
              rem_q[i]    <= '0;
              quo_q[i]    <= '0;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (cnt_q == LAST_CNT) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            quot_q     <= quot_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            quo_q <= quo_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_vec_quot = quot_q;
  assign o_div_zero = div_zero_q;
  assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_vec_div.sv
// Self-checking bench for vec_div. Expected results come from a plain
// integer-arithmetic model of signed fixed-point division with saturation.
module tb_vec_div;

  localparam int VS  = 16;
  localparam int W   = 32;
  localparam int F   = 16;
  localparam int LAT = W + F + 1;

  logic                   clk = 1'b0;
  logic                   i_rst_n;
  logic                   i_start;
  logic [VS-1:0][W-1:0]   i_vec_a;
  logic [VS-1:0][W-1:0]   i_vec_b;
  logic                   o_busy;
  logic                   o_done;
  logic [VS-1:0][W-1:0]   o_vec_quot;
  logic [VS-1:0]          o_div_zero;
  logic [VS-1:0]          o_ovf;

  int checks = 0;
  int errors = 0;

  logic [VS-1:0][W-1:0]   aVec, bVec, expQ, prevQ;
  logic [VS-1:0]          expDz, expOvf, prevDz, prevOvf;

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  vec_div #(.VEC_SIZE(VS), .FIXPOINT_WIDTH(W), .FRAC_BITS(F)) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_vec_a    (i_vec_a),
    .i_vec_b    (i_vec_b),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_vec_quot (o_vec_quot),
    .o_div_zero (o_div_zero),
    .o_ovf      (o_ovf)
  );

  // Watchdog in case the DUT stalls somewhere a bounded wait does not cover
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: exact (|a|*2^F)/|b| using 64-bit integers, then sign, saturation and divide-by-zero codes
  function automatic void refDiv(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic dz, output logic ovf);
    longint sa, sb, ma, mb, mq;
    bit     neg;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dz  = 1'b0;
    ovf = 1'b0;
    q   = '0;
    if (sb == 0) begin
      dz = 1'b1;
      if (sa == 0)     q = 32'h0000_0000;
      else if (sa > 0) q = 32'h7FFF_FFFF;
      else             q = 32'h8000_0000;
    end else begin
      ma  = (sa < 0) ? -sa : sa;
      mb  = (sb < 0) ? -sb : sb;
      mq  = (ma * 65536) / mb;
      neg = (sa < 0) != (sb < 0);
      if (!neg && mq > 64'sd2147483647) begin
        q = 32'h7FFF_FFFF; ovf = 1'b1;
      end else if (neg && mq > 64'sd2147483648) begin
        q = 32'h8000_0000; ovf = 1'b1;
      end else begin
        q = neg ? 32'(-mq) : 32'(mq);
      end
    end
  endfunction

  // Divisor mix: full-range, small magnitudes that provoke overflow, and zero
  function automatic logic [W-1:0] randDivisor();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom;
      1:       v = 32'($urandom_range(1, 32'h0003_FFFF));
      2:       v = -32'($urandom_range(1, 32'h0003_FFFF));
      default: v = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
    endcase
    return v;
  endfunction

  task automatic computeExpected();
    logic [W-1:0] q;
    logic         d, o;
    for (int i = 0; i < VS; i++) begin
      refDiv(aVec[i], bVec[i], q, d, o);
      expQ[i]   = q;
      expDz[i]  = d;
      expOvf[i] = o;
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkVec(input string tag, input logic [VS-1:0] obs, input logic [VS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare every result lane and both flag vectors against the model
  task automatic checkOutput(input string tag);
    for (int i = 0; i < VS; i++)
      checkWord($sformatf("%s_quot%0d", tag, i), o_vec_quot[i], expQ[i]);
    checkVec({tag, "_divzero"}, o_div_zero, expDz);
    checkVec({tag, "_ovf"}, o_ovf, expOvf);
  endtask

  // Drive operands with start, let the accepting edge pass, then confirm the job started
  task automatic applyStimulus(input bit holdStart);
    i_start = 1'b1;
    i_vec_a = aVec;
    i_vec_b = bVec;
    computeExpected();
    @(posedge clk); #1;
    if (!holdStart) i_start = 1'b0;
    checkBit("busy_after_accept", o_busy, 1'b1);
    checkBit("done_after_accept", o_done, 1'b0);
  endtask

  // Count edges until o_done is seen, with a bounded budget. Operands can be scrambled while waiting.
  task automatic waitDone(input string tag, input int expCycles, input bit scramble);
    int cycles;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
      if (!o_done && scramble) begin
        for (int k = 0; k < VS; k++) begin
          i_vec_a[k] = $urandom;
          i_vec_b[k] = $urandom;
        end
      end
    end while (!o_done && cycles < 200);
    checkInt({tag, "_latency"}, cycles, expCycles);
    checkBit({tag, "_busy_at_done"}, o_busy, 1'b0);
  endtask

  task automatic randomVectors();
    for (int i = 0; i < VS; i++) begin
      aVec[i] = $urandom;
      bVec[i] = randDivisor();
    end
  endtask

  // Directed and randomized steps, run in order
  initial begin
    int doneSeen;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_vec_a = '0;
    i_vec_b = '0;

    // Reset state
    #12;
    checkBit("reset_busy", o_busy, 1'b0);
    checkBit("reset_done", o_done, 1'b0);
    for (int i = 0; i < VS; i++) checkWord($sformatf("reset_quot%0d", i), o_vec_quot[i], 32'h0);
    checkVec("reset_divzero", o_div_zero, '0);
    checkVec("reset_ovf", o_ovf, '0);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);

    // Basic: 3.0 / 2.0 on every lane
    for (int i = 0; i < VS; i++) begin
      aVec[i] = 32'h0003_0000;
      bVec[i] = 32'h0002_0000;
    end
    applyStimulus(1'b0);
    waitDone("basic", LAT, 1'b0);
    checkOutput("basic");
    checkWord("basic_const_lane5", o_vec_quot[5], 32'h0001_8000);
    @(posedge clk); #1;
    checkBit("done_single_cycle", o_done, 1'b0);

    // Signs and truncation
    randomVectors();
    aVec[0] = 32'hFFFF_0000; bVec[0] = 32'h0003_0000;
    aVec[1] = 32'h0001_0000; bVec[1] = 32'hFFFD_0000;
    aVec[2] = 32'hFFFA_0000; bVec[2] = 32'hFFFE_0000;
    applyStimulus(1'b0);
    waitDone("signs", LAT, 1'b0);
    checkOutput("signs");
    checkWord("signs_const_lane0", o_vec_quot[0], 32'hFFFF_AAAB);
    checkWord("signs_const_lane1", o_vec_quot[1], 32'hFFFF_AAAB);
    checkWord("signs_const_lane2", o_vec_quot[2], 32'h0003_0000);

    // Divide by zero
    randomVectors();
    aVec[0] = 32'h0005_0000; bVec[0] = 32'h0;
    aVec[1] = 32'hFFFB_0000; bVec[1] = 32'h0;
    aVec[2] = 32'h0;         bVec[2] = 32'h0;
    applyStimulus(1'b0);
    waitDone("divzero", LAT, 1'b0);
    checkOutput("divzero");
    checkWord("divzero_const_lane0", o_vec_quot[0], 32'h7FFF_FFFF);
    checkWord("divzero_const_lane1", o_vec_quot[1], 32'h8000_0000);
    checkWord("divzero_const_lane2", o_vec_quot[2], 32'h0000_0000);
    checkVec("divzero_const_flags", {13'h0, o_div_zero[2:0]}, 16'h0007);

    // Overflow and the most-negative boundary
    randomVectors();
    aVec[0] = 32'h7530_0000; bVec[0] = 32'h0000_4000;
    aVec[1] = 32'h8AD0_0000; bVec[1] = 32'h0000_4000;
    aVec[2] = 32'h8000_0000; bVec[2] = 32'h0001_0000;
    applyStimulus(1'b0);
    waitDone("ovf", LAT, 1'b0);
    checkOutput("ovf");
    checkWord("ovf_const_lane0", o_vec_quot[0], 32'h7FFF_FFFF);
    checkWord("ovf_const_lane1", o_vec_quot[1], 32'h8000_0000);
    checkWord("ovf_const_lane2", o_vec_quot[2], 32'h8000_0000);
    checkVec("ovf_const_flags", {13'h0, o_ovf[2:0]}, 16'h0003);

    // Randomized jobs
    for (int n = 0; n < 4; n++) begin
      randomVectors();
      applyStimulus(1'b0);
      waitDone($sformatf("rand%0d", n), LAT, 1'b0);
      checkOutput($sformatf("rand%0d", n));
    end

    // Control: start held through RUN with changing operands, then back-to-back accept in the done cycle
    randomVectors();
    applyStimulus(1'b1);
    waitDone("ctl1", LAT, 1'b1);
    checkOutput("ctl1");
    prevQ   = expQ;
    prevDz  = expDz;
    prevOvf = expOvf;
    randomVectors();
    i_vec_a = aVec;
    i_vec_b = bVec;
    computeExpected();
    @(posedge clk); #1;
    i_start = 1'b0;
    checkBit("ctl2_busy_no_gap", o_busy, 1'b1);
    checkBit("ctl2_done_dropped", o_done, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < VS; i++) checkWord($sformatf("ctl_held_quot%0d", i), o_vec_quot[i], prevQ[i]);
    checkVec("ctl_held_divzero", o_div_zero, prevDz);
    checkVec("ctl_held_ovf", o_ovf, prevOvf);
    waitDone("ctl2", LAT - 10, 1'b0);
    checkOutput("ctl2");

    // Reset asserted asynchronously mid-run
    @(posedge clk); #1;
    randomVectors();
    applyStimulus(1'b0);
    repeat (20) @(posedge clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    checkBit("midreset_busy", o_busy, 1'b0);
    checkBit("midreset_done", o_done, 1'b0);
    for (int i = 0; i < VS; i++) checkWord($sformatf("midreset_quot%0d", i), o_vec_quot[i], 32'h0);
    checkVec("midreset_divzero", o_div_zero, '0);
    checkVec("midreset_ovf", o_ovf, '0);
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    doneSeen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (o_done) doneSeen++;
    end
    checkInt("midreset_no_done", doneSeen, 0);
    checkBit("midreset_idle_busy", o_busy, 1'b0);
    randomVectors();
    applyStimulus(1'b0);
    waitDone("postreset", LAT, 1'b0);
    checkOutput("postreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
